hint_calculator: RTL and testbench

Computes the Mastermind hint pair (green = right colour, right position; yellow = right colour, wrong position) for one submitted guess against the secret. It sits downstream of board guess entry (triggered when the board marks a guess entered) and upstream of hint storage and display: it fills `calculated_green`, `calculated_yellow`, `analyzed_guess` and `analyzed_secret` of the board state, which the hint RAM writer stores at `ram_hints_offset`. It is a deterministic two-pass sequential matcher that processes one pin per clock.

---
 rtl/hint_calculator_if.sv | 39 +++
 rtl/hint_calculator.sv | 194 +++++++++++++++++++
 tb/tb_hint_calculator.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/hint_calculator_if.sv
// Request/response bundle between the board logic and hint_calculator.
// The win flag exists only when HINT_EARLY_WIN_EN is defined.
interface hint_calculator_if #(
    parameter int N_MAX   = 20,
    parameter int COLOR_W = 5,
    parameter int POS_W   = 5
);
    logic                               start;
    logic [POS_W-1:0]                   pins_count;
    logic [0:N_MAX-1][COLOR_W-1:0]      guess;
    logic [0:N_MAX-1][COLOR_W-1:0]      secret;
    logic                               busy;
    logic                               done;
    logic [POS_W-1:0]                   green;
    logic [POS_W-1:0]                   yellow;
    logic [N_MAX-1:0]                   analyzed_guess;
    logic [N_MAX-1:0]                   analyzed_secret;
`ifdef HINT_EARLY_WIN_EN
    logic                               win;

    modport master (
        output start, pins_count, guess, secret,
        input  busy, done, green, yellow, analyzed_guess, analyzed_secret, win
    );
    modport slave (
        input  start, pins_count, guess, secret,
        output busy, done, green, yellow, analyzed_guess, analyzed_secret, win
    );
`else
    modport master (
        output start, pins_count, guess, secret,
        input  busy, done, green, yellow, analyzed_guess, analyzed_secret
    );
    modport slave (
        input  start, pins_count, guess, secret,
        output busy, done, green, yellow, analyzed_guess, analyzed_secret
    );
`endif
endinterface

// File: rtl/hint_calculator.sv
// Mastermind hint engine: one-pin-per-clock green pass then yellow pass.
// Optional macro HINT_EARLY_WIN_EN adds the win flag and skips YELLOW on an all-green guess.
module hint_calculator #(
    parameter int N_MAX   = 20,
    parameter int COLOR_W = 5,
    parameter int POS_W   = 5
) (
    input  logic              clk,
    input  logic              reset,
    hint_calculator_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, GREEN, YELLOW, DONE} state_t;

    localparam logic [POS_W-1:0] N_MAX_CNT = POS_W'(N_MAX);
    localparam logic [POS_W-1:0] ONE       = POS_W'(1);

    state_t                         state_reg, state_next;
    logic [0:N_MAX-1][COLOR_W-1:0]  guess_reg, guess_next;
    logic [0:N_MAX-1][COLOR_W-1:0]  secret_reg, secret_next;
    logic [POS_W-1:0]               n_reg, n_next;
    logic [POS_W-1:0]               idx_reg, idx_next;
    logic [POS_W-1:0]               green_reg, green_next;
    logic [POS_W-1:0]               yellow_reg, yellow_next;
    logic [N_MAX-1:0]               ag_reg, ag_next;
    logic [N_MAX-1:0]               as_reg, as_next;
    logic                           busy_reg, busy_next;
    logic                           done_reg, done_next;
`ifdef HINT_EARLY_WIN_EN
    logic                           win_reg, win_next;
`endif

    logic [POS_W-1:0]               n_clamped;
    logic [COLOR_W-1:0]             cur_guess;
    logic                           pin_eq;
    logic                           last_idx;
    logic [POS_W-1:0]               green_after;
    logic [N_MAX-1:0]               cand;
    logic                           found;
    logic [POS_W-1:0]               j_sel;

    assign n_clamped   = (bus.pins_count > N_MAX_CNT) ? N_MAX_CNT : bus.pins_count;
    assign cur_guess   = guess_reg[idx_reg];
    assign pin_eq      = (cur_guess == secret_reg[idx_reg]);
    assign last_idx    = (idx_reg == (n_reg - ONE));
    assign green_after = green_reg + POS_W'(pin_eq);

    // Secret slots still free to pair with the current guess pin; slots >= N never qualify.
    generate
        for (genvar gi = 0; gi < N_MAX; gi++) begin : g_cand
            assign cand[gi] = (POS_W'(gi) < n_reg) && !as_reg[gi] &&
                              (secret_reg[gi] == cur_guess);
        end
    endgenerate

    // Lowest-index candidate wins so duplicate colours are consumed left to right.
    always_comb begin
        found = 1'b0;
        j_sel = '0;
        for (int j = N_MAX - 1; j >= 0; j--) begin
            if (cand[j]) begin
                found = 1'b1;
                j_sel = POS_W'(j);
            end
        end
    end

    always_comb begin
        state_next  = state_reg;
        guess_next  = guess_reg;
        secret_next = secret_reg;
        n_next      = n_reg;
        idx_next    = idx_reg;
        green_next  = green_reg;
        yellow_next = yellow_reg;
        ag_next     = ag_reg;
        as_next     = as_reg;
`ifdef HINT_EARLY_WIN_EN
        win_next    = win_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    guess_next  = bus.guess;
                    secret_next = bus.secret;
                    n_next      = n_clamped;
                    idx_next    = '0;
                    green_next  = '0;
                    yellow_next = '0;
                    ag_next     = '0;
                    as_next     = '0;
`ifdef HINT_EARLY_WIN_EN
                    win_next    = 1'b0;
`endif
                    state_next  = (n_clamped == '0) ? DONE : GREEN;
                end
            end
            GREEN: begin
                if (pin_eq) begin
                    green_next       = green_after;
                    ag_next[idx_reg] = 1'b1;
                    as_next[idx_reg] = 1'b1;
                end
                if (last_idx) begin
                    idx_next = '0;
`ifdef HINT_EARLY_WIN_EN
                    state_next = (green_after == n_reg) ? DONE : YELLOW;
`else
                    state_next = YELLOW;
`endif
                end else begin
                    idx_next = idx_reg + ONE;
                end
            end
            YELLOW: begin
                if (!ag_reg[idx_reg] && found) begin
                    yellow_next      = yellow_reg + ONE;
                    ag_next[idx_reg] = 1'b1;
                    as_next[j_sel]   = 1'b1;
                end
                if (last_idx) begin
                    idx_next   = '0;
                    state_next = DONE;
                end else begin
                    idx_next = idx_reg + ONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        busy_next = (state_next != IDLE);
        done_next = (state_next == DONE);
`ifdef HINT_EARLY_WIN_EN
        if (state_next == DONE) begin
            win_next = (green_next == n_next) && (n_next != '0);
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            guess_reg  <= '0;
            secret_reg <= '0;
            n_reg      <= '0;
            idx_reg    <= '0;
            green_reg  <= '0;
            yellow_reg <= '0;
            ag_reg     <= '0;
            as_reg     <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
`ifdef HINT_EARLY_WIN_EN
            win_reg    <= 1'b0;
`endif
        end else begin
            guess_reg  <= guess_next;
            secret_reg <= secret_next;
            n_reg      <= n_next;
            idx_reg    <= idx_next;
            green_reg  <= green_next;
            yellow_reg <= yellow_next;
            ag_reg     <= ag_next;
            as_reg     <= as_next;
            busy_reg   <= busy_next;
            done_reg   <= done_next;
`ifdef HINT_EARLY_WIN_EN
            win_reg    <= win_next;
`endif
        end
    end

    assign bus.busy            = busy_reg;
    assign bus.done            = done_reg;
    assign bus.green           = green_reg;
    assign bus.yellow          = yellow_reg;
    assign bus.analyzed_guess  = ag_reg;
    assign bus.analyzed_secret = as_reg;
`ifdef HINT_EARLY_WIN_EN
    assign bus.win             = win_reg;
`endif

endmodule

// File: tb/tb_hint_calculator.sv
// Randomised bench for hint_calculator against a colour-histogram reference model.
module tb_hint_calculator;
    localparam int NM = 20;
    typedef logic [0:NM-1][4:0] cols_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hint_calculator_if #(.N_MAX(NM), .COLOR_W(5), .POS_W(5)) bus ();
    hint_calculator #(.N_MAX(NM), .COLOR_W(5), .POS_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic cols_t rand_cols(input int maxc);
        cols_t r;
        for (int i = 0; i < NM; i++) r[i] = 5'($urandom_range(0, maxc));
        return r;
    endfunction

    // Greens by position; yellows as sum over colours of min(count) minus greens;
    // masks by pairing each unmatched guess pin with the first free equal secret pin.
    task automatic model(input int n_in, input cols_t g, input cols_t s,
                         output int n, output int eg, output int ey,
                         output logic [19:0] mg, output logic [19:0] ms);
        int cg[32];
        int cs[32];
        for (int c = 0; c < 32; c++) begin
            cg[c] = 0;
            cs[c] = 0;
        end
        n  = (n_in > NM) ? NM : n_in;
        eg = 0;
        mg = '0;
        ms = '0;
        for (int i = 0; i < n; i++) begin
            if (g[i] == s[i]) begin
                eg++;
                mg[i] = 1'b1;
                ms[i] = 1'b1;
            end
            cg[g[i]]++;
            cs[s[i]]++;
        end
        ey = 0;
        for (int c = 0; c < 32; c++) ey += (cg[c] < cs[c]) ? cg[c] : cs[c];
        ey -= eg;
        for (int i = 0; i < n; i++) begin
            if (!mg[i]) begin
                for (int j = 0; j < n; j++) begin
                    if (!ms[j] && s[j] == g[i]) begin
                        mg[i] = 1'b1;
                        ms[j] = 1'b1;
                        break;
                    end
                end
            end
        end
    endtask

    task automatic run_op(input string tag, input int n_in, input cols_t g, input cols_t s,
                          input bit intrude);
        int n, eg, ey, lat, exp_lat;
        logic [19:0] mg, ms;
        model(n_in, g, s, n, eg, ey, mg, ms);
        exp_lat = (n == 0) ? 1 : 2 * n + 1;
`ifdef HINT_EARLY_WIN_EN
        if (n > 0 && eg == n) exp_lat = n + 1;
`endif
        @(negedge clk);
        bus.pins_count = 5'(n_in);
        bus.guess      = g;
        bus.secret     = s;
        bus.start      = 1'b1;
        lat = -1;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            bus.start      = (intrude && c == 2) ? 1'b1 : 1'b0;
            bus.guess      = rand_cols(31);
            bus.secret     = rand_cols(31);
            bus.pins_count = 5'($urandom_range(0, 31));
            if (c == 1) check({tag, "_busy"}, 32'(bus.busy), 32'd1);
            if (bus.done) begin
                lat = c;
                break;
            end
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_green"}, 32'(bus.green), 32'(eg));
        check({tag, "_yellow"}, 32'(bus.yellow), 32'(ey));
        check({tag, "_aguess"}, 32'(bus.analyzed_guess), 32'(mg));
        check({tag, "_asecret"}, 32'(bus.analyzed_secret), 32'(ms));
`ifdef HINT_EARLY_WIN_EN
        check({tag, "_win"}, 32'(bus.win), 32'(n > 0 && eg == n));
`endif
        $display("op %s n=%0d green=%0d yellow=%0d latency=%0d", tag, n, bus.green, bus.yellow, lat);
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
        check({tag, "_idle"}, 32'(bus.busy), 32'd0);
        check({tag, "_hold"}, 32'(bus.green), 32'(eg));
    endtask

    initial begin
        cols_t g, s;
        int    ndone;
        int    n;
        reset          = 1'b1;
        bus.start      = 1'b0;
        bus.pins_count = '0;
        bus.guess      = '0;
        bus.secret     = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_green", 32'(bus.green), 32'd0);
        check("rst_yellow", 32'(bus.yellow), 32'd0);
        check("rst_masks", 32'({bus.analyzed_guess, bus.analyzed_secret} != '0), 32'd0);
`ifdef HINT_EARLY_WIN_EN
        check("rst_win", 32'(bus.win), 32'd0);
`endif
        reset = 1'b0;

        g = rand_cols(31); s = rand_cols(31);
        g[0] = 5'd0; g[1] = 5'd2; g[2] = 5'd1; g[3] = 5'd5;
        s[0] = 5'd0; s[1] = 5'd1; s[2] = 5'd2; s[3] = 5'd3;
        run_op("basic", 4, g, s, 1'b0);
        check("basic_green_const", 32'(bus.green), 32'd1);
        check("basic_yellow_const", 32'(bus.yellow), 32'd2);
        check("basic_aguess_const", 32'(bus.analyzed_guess), 32'h7);

        g = rand_cols(31); s = rand_cols(31);
        g[0] = 5'd1; g[1] = 5'd2; g[2] = 5'd1; g[3] = 5'd1;
        s[0] = 5'd1; s[1] = 5'd1; s[2] = 5'd2; s[3] = 5'd2;
        run_op("dup", 4, g, s, 1'b0);

        g = rand_cols(31);
        run_op("allgreen20", 20, g, g, 1'b0);
        run_op("n0", 0, rand_cols(31), rand_cols(31), 1'b0);
        run_op("n25_green", 25, g, g, 1'b0);
        run_op("n25_rand", 25, rand_cols(3), rand_cols(3), 1'b0);
        run_op("intrude", 8, rand_cols(3), rand_cols(3), 1'b1);

        // Reset in the middle of an all-green N=8 run.
        g = rand_cols(31);
        @(negedge clk);
        bus.pins_count = 5'd8; bus.guess = g; bus.secret = g; bus.start = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (c == 5) reset = 1'b1;
        end
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_done", 32'(bus.done), 32'd0);
        check("mid_rst_green", 32'(bus.green), 32'd0);
        check("mid_rst_masks", 32'({bus.analyzed_guess, bus.analyzed_secret} != '0), 32'd0);
`ifdef HINT_EARLY_WIN_EN
        check("mid_rst_win", 32'(bus.win), 32'd0);
`endif
        reset = 1'b0;
        ndone = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        check("mid_rst_no_done", 32'(ndone), 32'd0);
        run_op("after_rst", 8, rand_cols(3), rand_cols(3), 1'b0);

        for (int k = 0; k < 40; k++) begin
            n = $urandom_range(0, 25);
            if (k % 2 == 0) begin
                g = rand_cols(3); s = rand_cols(3);
            end else begin
                g = rand_cols(31); s = rand_cols(31);
            end
            if (k % 7 == 0) s = g;
            run_op($sformatf("rnd%0d", k), n, g, s, (n >= 4) && (k % 3 == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
